// File: rtl/rx_frame_buffer_pkg.sv
// Types shared by the receive frame buffer and its descriptor FIFO.
`include "rx_buf_defs.vh"
package rx_frame_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = `RXB_ST_IDLE,
    ST_COLLECT = `RXB_ST_COLLECT,
    ST_DISCARD = `RXB_ST_DISCARD
  } wr_state_t;

  localparam int FCS_LEN = `RXB_FCS_LEN;

  typedef struct packed {
    logic ok;
    logic crc;
    logic abort;
    logic ovf;
  } stat_t;

endpackage

// File: rtl/rx_buf_defs.vh
// State encodings and framing constants shared by the receive frame buffer.
`ifndef RX_BUF_DEFS_VH
`define RX_BUF_DEFS_VH
`define RXB_ST_IDLE    3'b001
`define RXB_ST_COLLECT 3'b010
`define RXB_ST_DISCARD 3'b100
`define RXB_FCS_LEN    2
`endif

// File: rtl/rx_desc_fifo.sv
// First-word-fall-through FIFO of committed frame lengths; dout is the head entry while !empty.
// Zero latency from push to dout; push is ignored when full, pop ignored when empty.
module rx_desc_fifo #(
  parameter int W  = 12,
  parameter int AW = 2
) (
  input  logic         netclk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge netclk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge netclk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rx_frame_buffer.sv
// Buffers deframed bytes in a circular RAM and releases only good-FCS frames, FCS stripped.
// Read data is registered one cycle after fetch; rd_ready low holds the head byte, full RAM/FIFO drops frames.
module rx_frame_buffer
  import rx_frame_buffer_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int DESC_AW = 2,
  parameter int MIN_LEN = 4,
  parameter int MAX_LEN = 1026
) (
  input  logic            netclk,
  input  logic            reset_n,
  input  logic            byte_ready,
  input  logic [7:0]      din,
  input  logic            frame_complete,
  input  logic            frame_valid,
  input  logic            frame_abort,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [7:0]      rd_data,
  output logic            rd_last,
  output logic [ADDR_W:0] rd_len,
  output logic            stat_ok,
  output logic            stat_crc,
  output logic            stat_abort,
  output logic            stat_ovf
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] RAM_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0] MIN_C     = CW'(MIN_LEN);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_LEN);
  localparam logic [CW-1:0] FCS_C     = CW'(FCS_LEN);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [7:0]    mem [2**ADDR_W];
  wr_state_t     state, st_mid;
  stat_t         stat;
  logic          prev_byte, prev_cmp, prev_abt;
  logic          ev_byte, ev_cmp, ev_abt;
  logic [CW-1:0] wr_ptr, wr_base, rd_ptr, cnt, cnt_mid, wr_ptr_mid, rd_idx;
  logic [CW-1:0] desc_din, desc_dout;
  logic          desc_empty, desc_full;
  logic          ram_full, byte_acc, byte_ovf, commit, fetch, last_acc;

  assign ev_byte = byte_ready & ~prev_byte;
  assign ev_cmp  = frame_complete & ~prev_cmp;
  assign ev_abt  = frame_abort & ~prev_abt;

  // Byte step first, then the closing flag judges the frame including that byte.
  always_comb begin
    ram_full = ((wr_ptr - rd_ptr) == RAM_DEPTH);
    byte_acc = 1'b0;
    byte_ovf = 1'b0;
    if (ev_byte && !ev_abt) begin
      if (state == ST_IDLE) begin
        byte_ovf = ram_full;
        byte_acc = !ram_full;
      end else if (state == ST_COLLECT) begin
        byte_ovf = ram_full || (cnt == MAX_C);
        byte_acc = !byte_ovf;
      end
    end
    cnt_mid    = byte_acc ? cnt + ONE : cnt;
    wr_ptr_mid = byte_acc ? wr_ptr + ONE : wr_ptr;
    st_mid     = state;
    if (byte_ovf)      st_mid = ST_DISCARD;
    else if (byte_acc) st_mid = ST_COLLECT;
    commit   = ev_cmp && !ev_abt && (st_mid == ST_COLLECT) && (cnt_mid >= MIN_C)
               && frame_valid && !desc_full;
    desc_din = cnt_mid - FCS_C;
  end

  always_ff @(posedge netclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      prev_byte <= 1'b0;
      prev_cmp  <= 1'b0;
      prev_abt  <= 1'b0;
      wr_ptr    <= '0;
      wr_base   <= '0;
      cnt       <= '0;
      stat      <= '0;
    end else begin
      prev_byte <= byte_ready;
      prev_cmp  <= frame_complete;
      prev_abt  <= frame_abort;
      stat      <= '0;
      state     <= st_mid;
      cnt       <= cnt_mid;
      wr_ptr    <= wr_ptr_mid;
      if (ev_abt) begin
        if (state != ST_IDLE) begin
          state      <= ST_IDLE;
          cnt        <= '0;
          wr_ptr     <= wr_base;
          stat.abort <= (state == ST_COLLECT);
          stat.ovf   <= (state == ST_DISCARD);
        end
      end else if (ev_cmp && (st_mid != ST_IDLE)) begin
        state <= ST_IDLE;
        cnt   <= '0;
        if (commit) begin
          wr_base <= wr_ptr_mid;
          stat.ok <= 1'b1;
        end else begin
          // Bad FCS is reported only for a well-formed collected frame; every other drop is ovf.
          wr_ptr   <= wr_base;
          stat.crc <= (st_mid == ST_COLLECT) && (cnt_mid >= MIN_C) && !frame_valid;
          stat.ovf <= !((st_mid == ST_COLLECT) && (cnt_mid >= MIN_C) && !frame_valid);
        end
      end
    end
  end

  always_ff @(posedge netclk) begin
    if (byte_acc) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

  assign stat_ok    = stat.ok;
  assign stat_crc   = stat.crc;
  assign stat_abort = stat.abort;
  assign stat_ovf   = stat.ovf;

  rx_desc_fifo #(.W(CW), .AW(DESC_AW)) u_desc (
    .netclk  (netclk),
    .reset_n (reset_n),
    .push    (commit),
    .din     (desc_din),
    .pop     (last_acc),
    .dout    (desc_dout),
    .empty   (desc_empty),
    .full    (desc_full)
  );

  // rd_ptr always names the next byte to fetch; the FCS pair is skipped when the frame retires.
  assign fetch    = !desc_empty && (!rd_valid || (rd_ready && !rd_last));
  assign last_acc = rd_valid && rd_ready && rd_last;

  always_ff @(posedge netclk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
      rd_len   <= '0;
      rd_ptr   <= '0;
      rd_idx   <= '0;
    end else if (last_acc) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_idx   <= '0;
      rd_ptr   <= rd_ptr + FCS_C;
    end else if (fetch) begin
      rd_valid <= 1'b1;
      rd_data  <= mem[rd_ptr[ADDR_W-1:0]];
      rd_last  <= (rd_idx == desc_dout - ONE);
      rd_len   <= desc_dout;
      rd_idx   <= rd_idx + ONE;
      rd_ptr   <= rd_ptr + ONE;
    end
  end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Scoreboard bench for rx_frame_buffer: directed frames push expected bytes/stats, a monitor pops and compares.
module tb_rx_frame_buffer;

  logic        netclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        frame_complete = 1'b0;
  logic        frame_valid = 1'b0;
  logic        frame_abort = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid, rd_last;
  logic [7:0]  rd_data;
  logic [11:0] rd_len;
  logic        stat_ok, stat_crc, stat_abort, stat_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp_q[$];
  logic [1:0]  stat_q[$];
  logic [20:0] m_exp;
  logic [1:0]  m_code;
  logic [3:0]  m_stat;

  always #5 netclk = ~netclk;

  rx_frame_buffer #(.ADDR_W(11), .DESC_AW(2), .MIN_LEN(4), .MAX_LEN(1026)) dut (
    .netclk         (netclk),
    .reset_n        (reset_n),
    .byte_ready     (byte_ready),
    .din            (din),
    .frame_complete (frame_complete),
    .frame_valid    (frame_valid),
    .frame_abort    (frame_abort),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .rd_last        (rd_last),
    .rd_len         (rd_len),
    .stat_ok        (stat_ok),
    .stat_crc       (stat_crc),
    .stat_abort     (stat_abort),
    .stat_ovf       (stat_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stat codes: 0 ok, 1 crc, 2 abort, 3 ovf.
  always @(negedge netclk) begin
    if (reset_n === 1'b1) begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got byte %02h, expected no byte", rd_data);
        end else begin
          m_exp = exp_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(m_exp[7:0]));
          chk("rd_last", 32'(rd_last), 32'(m_exp[8]));
          chk("rd_len", 32'(rd_len), 32'(m_exp[20:9]));
        end
      end
      m_stat = {stat_ok, stat_crc, stat_abort, stat_ovf};
      if (m_stat != 4'b0000) begin
        if (stat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stat_unexpected: got %04b, expected no pulse", m_stat);
        end else begin
          m_code = stat_q.pop_front();
          chk("stat", 32'(m_stat), 32'(4'b1000 >> m_code));
        end
      end
    end
  end

  task automatic tick();
    @(posedge netclk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    if (seed == 0) return (i < 4) ? 8'(8'h11 * (i + 1)) : 8'(8'hA0 + i);
    return 8'(seed * 31 + i * 7 + (i >> 8) * 3);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    din = b;
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    tick();
  endtask

  task automatic send_cmp(input logic v);
    frame_valid = v;
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    tick();
  endtask

  task automatic send_abt();
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    tick();
  endtask

  // n received bytes including FCS; code < 0 means no stat pulse expected.
  task automatic frame(input int seed, input int n, input logic v, input int code);
    for (int i = 0; i < n; i++) send_byte(pat(seed, i));
    if (code >= 0) stat_q.push_back(2'(code));
    if (code == 0)
      for (int i = 0; i < n - 2; i++) exp_q.push_back({12'(n - 2), (i == n - 3), pat(seed, i)});
    send_cmp(v);
  endtask

  task automatic drain(input int budget, input bit with_data);
    int k = 0;
    while ((stat_q.size() != 0 || (with_data && exp_q.size() != 0)) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_pending", 32'(stat_q.size() + (with_data ? exp_q.size() : 0)), 32'd0);
    repeat (3) tick();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    chk({tag, "_rd_len"}, 32'(rd_len), 32'd0);
    chk({tag, "_stats"}, 32'({stat_ok, stat_crc, stat_abort, stat_ovf}), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();
    rd_ready = 1'b1;

    // Bad FCS frame rewinds; the following good frame starts at address 0.
    frame(0, 6, 1'b0, 1);
    drain(200, 1);
    chk("wr_ptr_after_crc", 32'(dut.wr_ptr), 32'd0);
    chk("rd_valid_after_crc", 32'(rd_valid), 32'd0);
    frame(0, 6, 1'b1, 0);
    drain(200, 1);
    chk("rd_ptr_after_good", 32'(dut.rd_ptr), 32'd6);

    // Abort, then two empty closing flags that must produce no pulse.
    for (int i = 0; i < 3; i++) send_byte(pat(5, i));
    stat_q.push_back(2'd2);
    send_abt();
    send_cmp(1'b1);
    send_cmp(1'b1);
    drain(50, 1);
    chk("wr_ptr_after_abort", 32'(dut.wr_ptr), 32'd6);

    // Runt and oversize, each a single ovf.
    frame(3, 3, 1'b1, 3);
    drain(50, 1);
    frame(4, 1027, 1'b1, 3);
    drain(50, 1);
    chk("wr_ptr_after_oversize", 32'(dut.wr_ptr), 32'd6);
    chk("rd_valid_after_oversize", 32'(rd_valid), 32'd0);

    // Descriptor FIFO full: four commits, fifth dropped; head byte held while stalled.
    rd_ready = 1'b0;
    for (int f = 0; f < 4; f++) frame(10 + f, 6, 1'b1, 0);
    frame(14, 6, 1'b1, 3);
    drain(50, 0);
    repeat (5) tick();
    chk("stall_rd_valid", 32'(rd_valid), 32'd1);
    chk("stall_rd_data", 32'(rd_data), 32'(pat(10, 0)));
    chk("stall_rd_len", 32'(rd_len), 32'd4);
    rd_ready = 1'b1;
    drain(500, 1);
    chk("rd_ptr_after_fifo_full", 32'(dut.rd_ptr), 32'd30);

    // RAM full: one prefetched byte frees a slot, so 1024 + 1025 bytes fill it exactly.
    rd_ready = 1'b0;
    frame(20, 1024, 1'b1, 0);
    frame(21, 1025, 1'b1, 0);
    frame(22, 6, 1'b1, 3);
    drain(50, 0);
    chk("wr_ptr_ram_full", 32'(dut.wr_ptr), 32'd2079);
    chk("rd_ptr_ram_full", 32'(dut.rd_ptr), 32'd31);
    rd_ready = 1'b1;
    drain(6000, 1);
    frame(23, 6, 1'b1, 0);
    drain(200, 1);
    chk("rd_ptr_after_wrap", 32'(dut.rd_ptr), 32'd2085);

    // Reset while a frame is held at the output and another is being collected.
    rd_ready = 1'b0;
    frame(30, 6, 1'b1, 0);
    drain(50, 0);
    send_byte(8'h77);
    send_byte(8'h88);
    chk("pre_reset_rd_valid", 32'(rd_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    exp_q.delete();
    stat_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    rd_ready = 1'b1;
    frame(0, 6, 1'b1, 0);
    drain(200, 1);
    chk("rd_ptr_after_reset", 32'(dut.rd_ptr), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
- Downstream consumer of the receive deframer: takes its byte stream and frame status, and buffers whole frames in a circular byte RAM.
- Commits a frame only when it closes with a good FCS. Aborted, bad-FCS, runt, oversize and overflowed frames are discarded.
- Presents committed frames, with the 2 FCS bytes stripped, to the host side as a valid/ready byte stream with a last flag and length.

Parameters:
- ADDR_W, 11, log2 of data RAM depth (2048 bytes).
- DESC_AW, 2, log2 of descriptor FIFO depth (4 frames).
- MIN_LEN, 4, minimum received bytes including FCS; shorter frames are runts.
- MAX_LEN, 1026, maximum received bytes including FCS.

Ports:
- netclk  in  1  receive clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- byte_ready  in  1  deframer byte strobe (level; a rising edge means a new byte).
- din  in  8  deframer byte, valid at the byte_ready rising edge.
- frame_complete  in  1  closing flag seen (level; act on the rising edge).
- frame_valid  in  1  FCS good; sampled at the frame_complete rising edge.
- frame_abort  in  1  abort seen (act on the rising edge).
- rd_valid  out  1  rd_data holds a frame byte.
- rd_ready  in  1  host accepts a byte.
- rd_data  out  8  frame byte.
- rd_last  out  1  rd_data is the last payload byte of the frame.
- rd_len  out  ADDR_W+1  payload length (received length minus 2) of the head frame; valid while rd_valid.
- stat_ok  out  1  1-cycle pulse: frame committed.
- stat_crc  out  1  1-cycle pulse: frame dropped, bad FCS.
- stat_abort  out  1  1-cycle pulse: frame dropped, abort.
- stat_ovf  out  1  1-cycle pulse: frame dropped for runt, oversize, RAM full or descriptor FIFO full.

Behaviour:
- Reset:
  - State IDLE; all pointers 0; descriptor FIFO empty.
  - rd_valid, rd_last and all stat_* are 0; rd_data 0; rd_len 0.
  - Edge-detect history registers reset to 0.
- Input events:
  - Registered previous values of byte_ready, frame_complete and frame_abort.
  - ev_byte = byte_ready & ~prev; ev_cmp = frame_complete & ~prev; ev_abt = frame_abort & ~prev.
- Pointers:
  - wr_ptr (speculative write), wr_base (start of current frame), rd_ptr; all ADDR_W+1 bits, wrapping naturally.
  - RAM full when wr_ptr - rd_ptr == 2^ADDR_W.
- State IDLE:
  - ev_byte with RAM not full: write din at wr_ptr, set cnt=1, go to COLLECT.
  - ev_byte with RAM full: go to DISCARD.
  - ev_cmp with cnt 0 (back-to-back flags): ignored, no stat pulse.
- State COLLECT:
  - ev_byte: if RAM is full or cnt==MAX_LEN, go to DISCARD; otherwise write din and increment cnt.
  - ev_abt: wr_ptr <= wr_base; stat_abort; go to IDLE.
  - ev_cmp with cnt<MIN_LEN: rewind; stat_ovf; go to IDLE.
  - ev_cmp with frame_valid=0: rewind; stat_crc; go to IDLE.
  - ev_cmp with descriptor FIFO full: rewind; stat_ovf; go to IDLE.
  - ev_cmp otherwise: push cnt-2 to the descriptor FIFO; wr_base <= wr_ptr; stat_ok; go to IDLE.
- State DISCARD:
  - Ignore bytes.
  - ev_abt or ev_cmp: wr_ptr <= wr_base; stat_ovf; go to IDLE.
  - A single stat_ovf per frame, even if frame_valid=1.
- Simultaneous events:
  - ev_abt wins over ev_cmp and ev_byte.
  - ev_byte is processed before ev_cmp in the same cycle; the byte counts toward the frame.
- Read side:
  - rd_valid=1 when the descriptor FIFO is non-empty and the prefetch register is loaded.
  - RAM read is registered: 1-cycle latency from address to rd_data.
  - Within a frame, bytes stream back-to-back while rd_ready=1.
  - At most 1 idle cycle between frames.
  - rd_last=1 on byte rd_len-1.
  - On accepting the last byte: rd_ptr += 2 (skip FCS) and pop the descriptor.
  - rd_data, rd_last and rd_len hold stable while rd_valid & ~rd_ready.
  - Reads touch only committed data; writes never pass rd_ptr.
- Frame length:
  - Minimum payload delivered is MIN_LEN-2.
  - Payload length 0 is impossible with MIN_LEN≥3.

Decomposition:
- Include file rx_buf_defs.vh: state encodings IDLE/COLLECT/DISCARD (one-hot, 3 bits), FCS_LEN=2.
- Sub-module rx_desc_fifo: synchronous FIFO of ADDR_W+1-bit lengths, depth 2^DESC_AW.
  - Ports: push, din, pop, dout, empty, full.
  - First-word-fall-through.
- Data RAM inferred inline as a simple dual-port array.

Test Plan:
- Good frame 6 bytes (4 payload 11 22 33 44 + FCS), ev_cmp with frame_valid=1 -> stat_ok; rd_len=4; bytes 11 22 33 44 with rd_last on 44; rd_ptr ends at 6.
- Same frame with frame_valid=0 -> stat_crc; rd_valid stays 0; wr_ptr back to 0; the next good frame is read starting at address 0.
- 3 bytes then frame_abort rising -> stat_abort only; no descriptor pushed. Then two flags with no bytes -> no stat pulse.
- Runt and oversize:
  - 3-byte frame with MIN_LEN=4, ev_cmp -> stat_ovf.
  - MAX_LEN+1 bytes, then ev_cmp with frame_valid=1 -> exactly one stat_ovf; buffer empty.
- Full conditions:
  - rd_ready=0 while 5 good frames arrive -> 4 stat_ok then stat_ovf (descriptor FIFO full).
  - Fill RAM to 2048 bytes -> next frame stat_ovf.
  - After draining with rd_ready=1 -> data integrity across pointer wrap.
- reset_n low mid-COLLECT and mid-read -> all outputs 0 immediately; after release, a fresh 6-byte good frame is delivered correctly.
